// File: rtl/hmmm_bus_responder.sv
// hmmm_bus_responder: responder side of the HMMM processor memory bus.
// Holds program/data RAM, loads it from a host port while the CPU is held in reset,
// and maps the top three addresses to halt, status and a buffered 8-bit output port.
//
// Ports:
//   ph1, ph2      two-phase non-overlapping clocks; state is captured on the rising edge of ph2,
//                 so every output is stable from that edge through the following ph1
//   reset         synchronous, active-high, sampled with ph2
//   mem_write     CPU write strobe, one full cycle per write
//   adr           CPU address
//   mem_data_in   CPU write data (low byte)
//   mem_data_out  read data to the CPU, combinational from adr
//   cpu_reset     reset to the processor, high outside RUN
//   ld_valid/ld_ready/ld_data  host program-load handshake
//   ld_done       host signals that the program is complete
//   out_valid/out_ready/out_data  output FIFO drain handshake, out_data is the FIFO head
module hmmm_bus_responder #(
  parameter int unsigned            ADDR_WIDTH = 8,
  parameter int unsigned            DATA_WIDTH = 16,
  parameter int unsigned            FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] HALT_ADR   = 8'hFD,
  parameter logic [ADDR_WIDTH-1:0] STAT_ADR   = 8'hFE,
  parameter logic [ADDR_WIDTH-1:0] OUT_ADR    = 8'hFF
) (
  input  logic                  ph1,
  input  logic                  ph2,
  input  logic                  reset,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] adr,
  input  logic [7:0]            mem_data_in,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  cpu_reset,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned NumWords = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StLoad, StRun, StHalt} state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] ld_ptr_q, ld_ptr_d;
  logic [DATA_WIDTH-1:0] mem [NumWords];

  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]      count_q, count_d;
  logic            overflow_q, overflow_d;

  logic        full, empty;
  logic        ld_accept;
  logic        run_wr, ram_wr;
  logic        push_req, push, pop, drop;
  logic [15:0] stat_word;

  // The clocks must never overlap: ph1 has to be low whenever ph2 rises.
  clk_nonoverlap: assert property (@(posedge ph2) !ph1);

  always_comb begin
    full      = (count_q == 5'(FIFO_DEPTH));
    empty     = (count_q == 5'd0);
    ld_ready  = (state_q == StLoad) && (ld_ptr_q < HALT_ADR);
    ld_accept = ld_valid && ld_ready;
    run_wr    = (state_q == StRun) && mem_write;
    ram_wr    = run_wr && (adr < HALT_ADR);
    pop       = !empty && out_ready;
    push_req  = run_wr && (adr == OUT_ADR);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push      = push_req && (!full || pop);
    drop      = push_req && full && !pop;
    count_d   = count_q + 5'(push) - 5'(pop);
    overflow_d = overflow_q || drop;
    ld_ptr_d  = ld_accept ? ld_ptr_q + 1'b1 : ld_ptr_q;
    stat_word = {8'h00, full, empty, overflow_q, count_q};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (ld_done) state_d = StRun;
      StRun:   if (run_wr && (adr == HALT_ADR)) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StLoad;
    endcase
  end

  always_comb begin
    cpu_reset    = (state_q != StRun);
    out_valid    = !empty;
    out_data     = empty ? 8'h00 : fifo_q[rd_ptr_q];
    mem_data_out = '0;
    if (state_q == StRun) begin
      if (adr < HALT_ADR) begin
        mem_data_out = mem[adr];
      end else if (adr == STAT_ADR) begin
        mem_data_out = DATA_WIDTH'(stat_word);
      end
    end
  end

  always_ff @(posedge ph2) begin
    if (reset) begin
      state_q    <= StLoad;
      ld_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_ptr_q   <= ld_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is never cleared; RAM contents survive reset.
  always_ff @(posedge ph2) begin
    if (!reset) begin
      if (ld_accept) begin
        mem[ld_ptr_q] <= ld_data;
      end else if (ram_wr) begin
        mem[adr] <= DATA_WIDTH'(mem_data_in);
      end
      if (push) fifo_q[wr_ptr_q] <= mem_data_in;
    end
  end

endmodule

// File: tb/tb_hmmm_bus_responder.sv
// Self-checking bench for hmmm_bus_responder: directed scenarios with an output-byte scoreboard.
module tb_hmmm_bus_responder;

  logic        ph1, ph2, reset;
  logic        mem_write;
  logic [7:0]  adr, mem_data_in;
  logic [15:0] mem_data_out;
  logic        cpu_reset;
  logic        ld_valid, ld_ready, ld_done;
  logic [15:0] ld_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  hmmm_bus_responder dut (
    .ph1          (ph1),
    .ph2          (ph2),
    .reset        (reset),
    .mem_write    (mem_write),
    .adr          (adr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .cpu_reset    (cpu_reset),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_done      (ld_done),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
  );

  initial begin
    ph1 = 1'b0;
    ph2 = 1'b0;
    forever begin
      ph1 = 1'b1; #4;
      ph1 = 1'b0; #1;
      ph2 = 1'b1; #4;
      ph2 = 1'b0; #1;
    end
  end

  // Advance to just after the next capturing edge; inputs are driven here.
  task automatic tick();
    @(posedge ph2);
    #2;
  endtask

  // Compares every byte the host drains against the scoreboard.
  task automatic run_monitor();
    logic [7:0] exp_b;
    forever begin
      @(negedge ph1);
      if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected: got out_data=%h, no entry expected", out_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (out_data !== exp_b) begin
            failures++;
            $display("FAIL out_data: got %h expected %h", out_data, exp_b);
          end
        end
      end
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    mem_write = 1'b1; adr = a; mem_data_in = d;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic check_read(input string name, input logic [7:0] a, input logic [15:0] exp);
    adr = a;
    #1;
    checks++;
    if (mem_data_out !== exp) begin
      failures++;
      $display("FAIL %s: adr=%h got %h expected %h", name, a, mem_data_out, exp);
    end
  endtask

  task automatic drain(input string name, input int budget);
    out_ready = 1'b1;
    for (int k = 0; k < budget && out_valid === 1'b1; k++) tick();
    #1;
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: out_valid=%b pending=%0d expected 0/0", name, out_valid, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    adr = 8'h01;
    #1;
    checks++;
    if ({cpu_reset, ld_ready, out_valid, out_data, mem_data_out} !== {3'b110, 8'h00, 16'h0000}) begin
      failures++;
      $display("FAIL reset_state: got cr=%b lr=%b ov=%b od=%h md=%h expected 1 1 0 00 0000",
               cpu_reset, ld_ready, out_valid, out_data, mem_data_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_load();
    ld_valid = 1'b1; ld_data = 16'h1234;
    tick();
    ld_data = 16'h0001;
    tick();
    ld_data = 16'h00FF; ld_done = 1'b1;
    #1;
    checks++;
    if (cpu_reset !== 1'b1) begin
      failures++;
      $display("FAIL load_cpu_reset: got %b expected 1", cpu_reset);
    end
    tick();
    ld_valid = 1'b0; ld_done = 1'b0;
    #1;
    checks++;
    if (cpu_reset !== 1'b0) begin
      failures++;
      $display("FAIL run_cpu_reset: got %b expected 0", cpu_reset);
    end
    check_read("load_word1", 8'h01, 16'h0001);
    check_read("load_word0", 8'h00, 16'h1234);
    check_read("load_word2", 8'h02, 16'h00FF);
  endtask

  task automatic test_ram_write();
    cpu_write(8'h10, 8'h2D);
    check_read("ram_write", 8'h10, 16'h002D);
    check_read("status_idle", 8'hFE, 16'h0040);
    check_read("read_halt_adr", 8'hFD, 16'h0000);
  endtask

  task automatic test_fifo_fill();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      cpu_write(8'hFF, 8'(i));
    end
    check_read("status_full_ovf", 8'hFE, 16'h00A4);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h01) begin
      failures++;
      $display("FAIL fifo_head: got ov=%b od=%h expected 1 01", out_valid, out_data);
    end
    drain("fifo_drain", 4);
    check_read("status_sticky_ovf", 8'hFE, 16'h0060);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      cpu_write(8'hFF, 8'(i));
    end
    exp_q.push_back(8'h09);
    out_ready = 1'b1;
    cpu_write(8'hFF, 8'h09);
    out_ready = 1'b0;
    check_read("status_push_pop_full", 8'hFE, 16'h00A4);
    drain("b2b_drain", 8);
  endtask

  task automatic test_halt();
    cpu_write(8'h20, 8'h11);
    out_ready = 1'b0;
    exp_q.push_back(8'h77);
    cpu_write(8'hFF, 8'h77);
    cpu_write(8'hFD, 8'h00);
    #1;
    checks++;
    if (cpu_reset !== 1'b1) begin
      failures++;
      $display("FAIL halt_cpu_reset: got %b expected 1", cpu_reset);
    end
    cpu_write(8'h20, 8'h55);
    cpu_write(8'hFF, 8'h99);
    check_read("halt_read_zero", 8'h20, 16'h0000);
    drain("halt_drain", 6);
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b0 || cpu_reset !== 1'b1) begin
      failures++;
      $display("FAIL halt_hold: got ov=%b cr=%b expected 0 1", out_valid, cpu_reset);
    end
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0; ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    check_read("halt_ram_kept", 8'h20, 16'h0011);
    check_read("reset_ram_kept", 8'h00, 16'h1234);
  endtask

  task automatic test_load_full();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ld_valid = 1'b1;
    for (int i = 0; i < 'hFD; i++) begin
      ld_data = 16'h0100 + 16'(i);
      tick();
    end
    #1;
    checks++;
    if (ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL ld_ready_full: got %b expected 0", ld_ready);
    end
    ld_data = 16'hBEEF;
    tick();
    ld_valid = 1'b0; ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    check_read("load_last", 8'hFC, 16'h01FC);
    check_read("load_no_wrap", 8'h00, 16'h0100);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'hA1 + 8'(i));
      cpu_write(8'hFF, 8'hA1 + 8'(i));
    end
    out_ready = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    #1;
    exp_q.delete();
    checks++;
    if ({out_valid, out_data, cpu_reset, ld_ready} !== {1'b0, 8'h00, 2'b11}) begin
      failures++;
      $display("FAIL reset_mid_drain: got ov=%b od=%h cr=%b lr=%b expected 0 00 1 1",
               out_valid, out_data, cpu_reset, ld_ready);
    end
    reset = 1'b0; out_ready = 1'b0;
    ld_valid = 1'b1; ld_data = 16'hCAFE; ld_done = 1'b1;
    tick();
    ld_valid = 1'b0; ld_done = 1'b0;
    check_read("reload_ptr0", 8'h00, 16'hCAFE);
    check_read("status_after_reset", 8'hFE, 16'h0040);
  endtask

  initial begin
    reset = 1'b1; mem_write = 1'b0; adr = 8'h00; mem_data_in = 8'h00;
    ld_valid = 1'b0; ld_data = 16'h0000; ld_done = 1'b0; out_ready = 1'b0;
    fork
      run_monitor();
    join_none
    test_reset();
    test_load();
    test_ram_write();
    test_fifo_fill();
    test_back_to_back();
    test_halt();
    test_load_full();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
